// File: rtl/bnn_feature_streamer.sv
// Streams quantised features into a flat classifier bus, waits out the classifier
// latency, and returns prediction/label/hit with saturating scoreboard counters.
module bnn_feature_streamer #(
  parameter  int unsigned FEAT_CNT  = 11,
  parameter  int unsigned FEAT_BITS = 4,
  parameter  int unsigned CLASS_CNT = 7,
  parameter  int unsigned LATENCY   = 48,
  parameter  int unsigned CNT_BITS  = 16,
  localparam int unsigned CLS_W     = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  input  logic [CLS_W-1:0]              in_label,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          clf_start,
  input  logic [CLS_W-1:0]              pred_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CLS_W-1:0]              out_pred,
  output logic [CLS_W-1:0]              out_label,
  output logic                          out_hit,
  output logic [CNT_BITS-1:0]           total_cnt,
  output logic [CNT_BITS-1:0]           correct_cnt
);

  localparam int unsigned VEC_W  = FEAT_CNT * FEAT_BITS;
  localparam int unsigned IDX_W  = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [VEC_W-1:0]    asm_q;
  logic [VEC_W-1:0]    asm_d;
  logic [WAIT_W-1:0]   wcnt_q;
  logic [VEC_W-1:0]    feat_q;
  logic                start_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CLS_W-1:0]    pred_q;
  logic [CLS_W-1:0]    label_q;
  logic                hit_q;
  logic [CNT_BITS-1:0] total_q;
  logic [CNT_BITS-1:0] correct_q;
  int unsigned         slot_base;

  logic accept_c;
  logic last_c;

  assign accept_c = in_valid && in_ready_q;
  assign last_c   = (idx_q == IDX_W'(FEAT_CNT - 1));

  // Assembly view including the beat accepted this cycle, so the final beat lands on the bus too.
  always_comb begin
    asm_d     = asm_q;
    slot_base = 32'(idx_q) * FEAT_BITS;
    if (accept_c) begin
      asm_d[slot_base +: FEAT_BITS] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      asm_q       <= '0;
      wcnt_q      <= '0;
      feat_q      <= '0;
      start_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      pred_q      <= '0;
      label_q     <= '0;
      hit_q       <= 1'b0;
      total_q     <= '0;
      correct_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (accept_c) begin
            asm_q <= asm_d;
            if (last_c) begin
              feat_q     <= asm_d;
              label_q    <= in_label;
              idx_q      <= '0;
              wcnt_q     <= '0;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              state_q    <= ST_WAIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_q + WAIT_W'(1);
          // Counter reads LATENCY-1 on the edge exactly LATENCY cycles after the bus update.
          if (wcnt_q == WAIT_W'(LATENCY - 1)) begin
            pred_q      <= pred_in;
            hit_q       <= (pred_in == label_q);
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (total_q != {CNT_BITS{1'b1}}) begin
              total_q <= total_q + CNT_BITS'(1);
            end
            if (hit_q && (correct_q != {CNT_BITS{1'b1}})) begin
              correct_q <= correct_q + CNT_BITS'(1);
            end
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign features    = feat_q;
  assign clf_start   = start_q;
  assign out_valid   = out_valid_q;
  assign out_pred    = pred_q;
  assign out_label   = label_q;
  assign out_hit     = hit_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;

endmodule
